// File: rtl/add_round_key_expand_if.sv
// Request/result bundle between the MixColumns stage and the AddRoundKey + key-expansion stage.
// The requester drives enable/round_in/state/key_in; the round stage returns the registered result.
interface add_round_key_expand_if;
    logic         enable;
    logic [3:0]   round_in;
    logic [127:0] state;
    logic [127:0] key_in;
    logic [127:0] state_out;
    logic [127:0] key_out;
    logic         done;

    modport master (
        output enable, round_in, state, key_in,
        input  state_out, key_out, done
    );

    modport slave (
        input  enable, round_in, state, key_in,
        output state_out, key_out, done
    );
endinterface

// File: rtl/add_round_key_expand.sv
// AES-128 AddRoundKey stage with on-the-fly next-key expansion.
// A single S-box is time-shared over the four bytes of RotWord(w3), one byte per cycle.
module add_round_key_expand (
    input  logic                   clk,
    input  logic                   rst,
    add_round_key_expand_if.slave  bus
);
    localparam int NB = 4;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {IDLE, SUB, EXP, OUT} fsm_t;

    fsm_t         r_fsm;
    logic [1:0]   r_cnt;
    logic [3:0]   r_round;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [127:0] r_rkey;
    logic [31:0]  r_t;
    logic [127:0] r_state_out;
    logic [127:0] r_key_out;
    logic         r_done;

    logic [31:0]  w_w3;
    logic [1:0]   w_rot_idx;
    logic [7:0]   w_sbox_in;
    logic [7:0]   w_sbox_out;
    logic [7:0]   w_rcon;
    logic [31:0]  w_prev;
    logic [127:0] w_next_key;

    // RotWord: byte counter selects w3 byte (counter+1) mod 4, wrapping in 2 bits
    assign w_w3       = r_key[127:96];
    assign w_rot_idx  = r_cnt + 2'd1;
    assign w_sbox_in  = w_w3[{w_rot_idx, 3'b000} +: 8];
    assign w_sbox_out = SBOX[w_sbox_in];

    always_comb begin
        case (r_round)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // Word chain nw0 = w0^t, nwi = wi^nw(i-1), with Rcon folded into byte 0 of t
    always_comb begin
        w_next_key = '0;
        w_prev     = r_t ^ {24'h0, w_rcon};
        for (int i = 0; i < NB; i++) begin
            w_prev                = r_key[i*32 +: 32] ^ w_prev;
            w_next_key[i*32 +: 32] = w_prev;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_cnt       <= '0;
            r_round     <= '0;
            r_state     <= '0;
            r_key       <= '0;
            r_rkey      <= '0;
            r_t         <= '0;
            r_state_out <= '0;
            r_key_out   <= '0;
            r_done      <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (bus.enable) begin
                        r_state <= bus.state;
                        r_key   <= bus.key_in;
                        r_round <= bus.round_in;
                        r_cnt   <= '0;
                        r_done  <= 1'b0;
                        // round 0 spends one pass-through cycle in EXP to keep its 2-cycle latency
                        r_fsm   <= (bus.round_in == 4'd0) ? EXP : SUB;
                    end
                end
                SUB: begin
                    r_t[{r_cnt, 3'b000} +: 8] <= w_sbox_out;
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_fsm <= EXP;
                    end
                end
                EXP: begin
                    r_rkey <= (r_round == 4'd0) ? r_key : w_next_key;
                    r_fsm  <= OUT;
                end
                OUT: begin
                    r_state_out <= r_state ^ r_rkey;
                    r_key_out   <= r_rkey;
                    r_done      <= 1'b1;
                    r_fsm       <= IDLE;
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign bus.state_out = r_state_out;
    assign bus.key_out   = r_key_out;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_add_round_key_expand.sv
// Directed and randomized checks of add_round_key_expand against an AES-128 key schedule model
// built from GF(2^8) arithmetic (S-box derived from multiplicative inverse + affine map).
module tb_add_round_key_expand;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    add_round_key_expand_if bus ();

    add_round_key_expand dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] ref_rcon(input logic [3:0] rnd);
        logic [7:0] v = 8'h01;
        if (rnd == 4'd0 || rnd > 4'd10) return 8'h00;
        for (int i = 1; i < int'(rnd); i++) v = gmul(v, 8'h02);
        return v;
    endfunction

    function automatic logic [127:0] ref_key(input logic [127:0] key, input logic [3:0] rnd);
        logic [7:0]   kb [4][4];
        logic [7:0]   tmp [4];
        logic [127:0] res;
        if (rnd == 4'd0) return key;
        for (int c = 0; c < 4; c++)
            for (int b = 0; b < 4; b++)
                kb[c][b] = key[c*32 + 8*b +: 8];
        for (int b = 0; b < 4; b++) tmp[b] = ref_sbox(kb[3][(b+1) % 4]);
        tmp[0] ^= ref_rcon(rnd);
        for (int c = 0; c < 4; c++)
            for (int b = 0; b < 4; b++) begin
                if (c == 0) kb[c][b] ^= tmp[b];
                else        kb[c][b] ^= kb[c-1][b];
            end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int b = 0; b < 4; b++)
                res[c*32 + 8*b +: 8] = kb[c][b];
        return res;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; enable is sampled at the following posedge, then inputs are scrambled.
    task automatic start_req(input logic [3:0] rnd, input logic [127:0] st, input logic [127:0] key);
        bus.round_in = rnd;
        bus.state    = st;
        bus.key_in   = key;
        bus.enable   = 1'b1;
        @(negedge clk);
        bus.enable   = 1'b0;
        bus.state    = {$urandom, $urandom, $urandom, $urandom};
        bus.key_in   = {$urandom, $urandom, $urandom, $urandom};
        bus.round_in = 4'($urandom);
    endtask

    // Counts posedges until done is seen (99 when it never arrives).
    task automatic wait_done(output int lat);
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_req(input string tag, input logic [3:0] rnd, input logic [127:0] st,
                          input logic [127:0] key);
        int lat;
        logic [127:0] ek;
        ek = ref_key(key, rnd);
        start_req(rnd, st, key);
        wait_done(lat);
        chk({tag, " latency"}, 128'(lat), (rnd == 4'd0) ? 128'd2 : 128'd6);
        chk({tag, " key_out"}, bus.key_out, ek);
        chk({tag, " state_out"}, bus.state_out, st ^ ek);
        $display("req %s round=%0d key_out=%h state_out=%h lat=%0d", tag, rnd, bus.key_out, bus.state_out, lat);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] k0, st0, k10, ka, sa, kr;
        logic [127:0] hold_key, hold_state;
        int lat;

        k0  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
        st0 = 128'h340737e0a29831318d305a88a8f64332;
        k10 = 128'h6e005c574129d12821dcfa19f36677ac;

        rst          = 1'b1;
        bus.enable   = 1'b0;
        bus.round_in = '0;
        bus.state    = '0;
        bus.key_in   = '0;
        repeat (3) @(negedge clk);
        chk("reset done", 128'(bus.done), 128'd0);
        chk("reset state_out", bus.state_out, 128'd0);
        chk("reset key_out", bus.key_out, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Known-answer vectors
        do_req("r0", 4'd0, st0, k0);
        chk("r0 kat state", bus.state_out, 128'h0848f8e92a8dc69a2be2f4a0bee33d19);
        chk("r0 kat key", bus.key_out, k0);
        do_req("r1", 4'd1, 128'd0, k0);
        chk("r1 kat key", bus.key_out, 128'h05766c2a3939a323b12c548817fefaa0);
        chk("r1 kat state", bus.state_out, 128'h05766c2a3939a323b12c548817fefaa0);
        do_req("r10", 4'd10, {128{1'b1}}, k10);
        chk("r10 kat key", bus.key_out, 128'ha60c63b6c80c3fe18925eec9a8f914d0);
        chk("r10 kat state", bus.state_out, ~128'ha60c63b6c80c3fe18925eec9a8f914d0);

        // Busy: second enable during SUB is dropped
        ka = {$urandom, $urandom, $urandom, $urandom};
        sa = {$urandom, $urandom, $urandom, $urandom};
        start_req(4'd1, sa, ka);
        bus.round_in = 4'd5;
        bus.state    = ~sa;
        bus.key_in   = ~ka;
        bus.enable   = 1'b1;
        @(negedge clk);
        bus.enable   = 1'b0;
        wait_done(lat);
        chk("busy latency", 128'(lat), 128'd5);
        chk("busy key_out", bus.key_out, ref_key(ka, 4'd1));
        chk("busy state_out", bus.state_out, sa ^ ref_key(ka, 4'd1));
        $display("req busy key_out=%h state_out=%h", bus.key_out, bus.state_out);

        // Sticky done with enable held low (also proves the ignored enable was not queued)
        hold_key   = bus.key_out;
        hold_state = bus.state_out;
        repeat (20) @(negedge clk);
        chk("sticky done", 128'(bus.done), 128'd1);
        chk("sticky key_out", bus.key_out, hold_key);
        chk("sticky state_out", bus.state_out, hold_state);
        $display("sticky done=%0d key_out=%h", bus.done, bus.key_out);

        // Reset while in EXP discards the partial key
        start_req(4'd1, sa, ka);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst done", 128'(bus.done), 128'd0);
        chk("midrst state_out", bus.state_out, 128'd0);
        chk("midrst key_out", bus.key_out, 128'd0);
        $display("midrst done=%0d key_out=%h state_out=%h", bus.done, bus.key_out, bus.state_out);
        rst = 1'b0;
        @(negedge clk);
        do_req("post_rst", 4'd1, 128'd0, k0);

        // Randomized back-to-back requests, all rounds 0..15
        for (int n = 0; n < 16; n++) begin
            kr = {$urandom, $urandom, $urandom, $urandom};
            do_req($sformatf("rand%0d", n), 4'($urandom_range(0, 15)),
                   {$urandom, $urandom, $urandom, $urandom}, kr);
        end
        do_req("r15", 4'd15, 128'd0, kr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
